// File: rtl/neuron_mac_pkg.sv
// Shared definitions for the neuron multiply-accumulate stage: FSM state
// encoding and signed saturating arithmetic. The ReLU stage reuses these.
package neuron_mac_pkg;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_BIAS  = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    // Largest value of a signed two's complement number of the given width.
    function automatic logic signed [63:0] sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Most negative value of a signed two's complement number of the given width.
    function automatic logic signed [63:0] sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    // Signed add clamped to the range of 'width' bits. Operands are
    // sign-extended width-bit values, so the 64-bit sum is exact and an
    // overflow shows up as a value outside the narrow range.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int width);
        logic signed [63:0] s;
        s = a + b;
        if (s > sat_max(width)) begin
            return sat_max(width);
        end else if (s < sat_min(width)) begin
            return sat_min(width);
        end
        return s;
    endfunction

endpackage

// File: rtl/neuron_mac_weight_mem.sv
// Per-neuron weight store: one synchronous write port, one registered read
// port. Writes to addresses at or beyond numWeight are discarded so they can
// never alias onto a real weight.
module neuron_mac_weight_mem #(
    parameter int dataWidth = 16,
    parameter int numWeight = 784,
    parameter int addrWidth = 10,
    parameter int idxWidth  = 10
) (
    input  logic                 clk,
    input  logic                 wr_en_i,
    input  logic [addrWidth-1:0] wr_addr_i,
    input  logic [dataWidth-1:0] wr_data_i,
    input  logic                 rd_en_i,
    input  logic [idxWidth-1:0]  rd_addr_i,
    output logic [dataWidth-1:0] rd_data_o
);

    logic [dataWidth-1:0] mem_q [numWeight];
    logic [dataWidth-1:0] rd_data_q;
    logic                 wr_hit;

    assign wr_hit    = wr_en_i && (32'(wr_addr_i) < numWeight);
    assign rd_data_o = rd_data_q;

    // Storage write and registered read; read returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            mem_q[wr_addr_i[idxWidth-1:0]] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Neuron multiply-accumulate: streams numWeight signed words, multiplies each
// by its stored weight, accumulates with saturation, adds the bias and
// presents the pre-activation sum with a one-cycle out_valid strobe.
//
// Handshake: a word is consumed at a rising edge where in_valid && in_ready;
// in_ready is high only while collecting a vector. out_valid is a one-cycle
// strobe with no back-pressure; out_sum holds until the next result.
module neuron_mac
    import neuron_mac_pkg::*;
#(
    parameter int dataWidth      = 16,
    parameter int weightIntWidth = 4,
    parameter int numWeight      = 784,
    parameter int addrWidth      = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   w_wen,
    input  logic [addrWidth-1:0]   w_addr,
    input  logic [dataWidth-1:0]   w_data,
    input  logic                   b_wen,
    input  logic [2*dataWidth-1:0] b_data,
    input  logic                   in_valid,
    input  logic [dataWidth-1:0]   in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [2*dataWidth-1:0] out_sum
);

    localparam int SUM_W = 2 * dataWidth;
    localparam int IDX_W = (numWeight > 1) ? $clog2(numWeight) : 1;
    localparam logic [addrWidth-1:0] LAST_IDX = addrWidth'(numWeight - 1);

    // The weight format is only meaningful downstream; an integer part wider
    // than the word leaves this marker block in the elaborated hierarchy.
    if (weightIntWidth > dataWidth) begin : g_weight_int_width_too_wide
    end

    state_e                    state_q, state_d;
    logic [addrWidth-1:0]      cnt_q, cnt_d;
    logic                      v0_q, v1_q, v2_q;
    logic signed [dataWidth-1:0] x0_q, x1_q, w1_q;
    logic [dataWidth-1:0]      w_rd;
    logic signed [SUM_W-1:0]   prod_q, acc_q, acc_d, bias_q;
    logic [SUM_W-1:0]          out_sum_q, out_sum_d;
    logic                      out_valid_q, out_valid_d;
    logic                      accept, pipe_busy, cfg_wr_ok;
    logic signed [63:0]        acc_sum, bias_sum;

    assign in_ready  = (state_q == ST_ACC);
    assign accept    = in_valid && in_ready;
    assign pipe_busy = v0_q || v1_q || v2_q;
    // Configuration may only change between vectors, never under a live sum.
    assign cfg_wr_ok = (state_q == ST_ACC) && (cnt_q == '0) && !pipe_busy;

    assign acc_sum   = sat_add(64'(acc_q), 64'(prod_q), SUM_W);
    assign bias_sum  = sat_add(64'(acc_q), 64'(bias_q), SUM_W);

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;

    neuron_mac_weight_mem #(
        .dataWidth (dataWidth),
        .numWeight (numWeight),
        .addrWidth (addrWidth),
        .idxWidth  (IDX_W)
    ) u_weight_mem (
        .clk       (clk),
        .wr_en_i   (w_wen && cfg_wr_ok),
        .wr_addr_i (w_addr),
        .wr_data_i (w_data),
        .rd_en_i   (accept),
        .rd_addr_i (cnt_q[IDX_W-1:0]),
        .rd_data_o (w_rd)
    );

    // Next-state, counter, accumulator and output-register decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_sum_d   = out_sum_q;
        acc_d       = v2_q ? acc_sum[SUM_W-1:0] : acc_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Pipeline empty means the last product is in the accumulator.
                if (!pipe_busy) begin
                    state_d = ST_BIAS;
                end
            end
            ST_BIAS: begin
                out_sum_d   = bias_sum[SUM_W-1:0];
                out_valid_d = 1'b1;
                acc_d       = '0;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                state_d = ST_ACC;
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // Control state, valid tags, accumulator and outputs; cleared on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            cnt_q       <= '0;
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            v0_q        <= accept;
            v1_q        <= v0_q;
            v2_q        <= v1_q;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
        end
    end

    // Datapath stages advance only on valid-tagged data; bias is not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            x0_q <= in_data;
        end
        if (v0_q) begin
            x1_q <= x0_q;
            w1_q <= w_rd;
        end
        if (v1_q) begin
            prod_q <= SUM_W'(x1_q) * SUM_W'(w1_q);
        end
        if (b_wen && cfg_wr_ok) begin
            bias_q <= b_data;
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Randomised scoreboard bench for neuron_mac with numWeight=4, dataWidth=16.
module tb_neuron_mac;

  localparam int DW = 16;
  localparam int NW = 4;
  localparam int AW = 3;
  localparam int SW = 2 * DW;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_wen = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [DW-1:0] w_data = '0;
  logic          b_wen = 1'b0;
  logic [SW-1:0] b_data = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [SW-1:0] out_sum;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  neuron_mac #(
    .dataWidth(DW), .weightIntWidth(4), .numWeight(NW), .addrWidth(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .w_wen(w_wen), .w_addr(w_addr), .w_data(w_data),
    .b_wen(b_wen), .b_data(b_data),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_sum(out_sum)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passes = 0;
  logic [SW-1:0] exp_q[$];
  int            cyc_q[$];

  // reference model state
  logic signed [DW-1:0] wm [NW];
  logic signed [SW-1:0] bm;
  logic signed [DW-1:0] vec [NW];
  int                   gap [NW];
  logic [SW-1:0]        last_sum = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic longint clamp(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  // Dot product with saturation after every add, then the bias add.
  function automatic logic [SW-1:0] model_sum();
    longint acc = 0;
    for (int i = 0; i < NW; i++) acc = clamp(acc + longint'(vec[i]) * longint'(wm[i]));
    acc = clamp(acc + longint'(bm));
    return acc[SW-1:0];
  endfunction

  function automatic logic [DW-1:0] rand_word();
    case ($urandom_range(0, 3))
      0: return 16'h7FFF;
      1: return 16'h8000;
      default: return DW'($urandom);
    endcase
  endfunction

  // ---------------- driver tasks (all called at a negedge) ----------------
  task automatic write_weight(input int addr, input logic [DW-1:0] data);
    w_wen = 1'b1; w_addr = AW'(addr); w_data = data;
    @(negedge clk);
    w_wen = 1'b0;
    if (addr < NW) wm[addr] = data;
  endtask

  task automatic write_bias(input logic [SW-1:0] data);
    b_wen = 1'b1; b_data = data;
    @(negedge clk);
    b_wen = 1'b0;
    bm = data;
  endtask

  task automatic send_word(input logic [DW-1:0] x, output bit ok, output int acc_cyc);
    ok = 1'b0;
    acc_cyc = 0;
    in_valid = 1'b1;
    in_data = x;
    for (int t = 0; t < 50; t++) begin
      if (in_ready) begin
        acc_cyc = cyc + 1;
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", ok, 1);
  endtask

  task automatic send_vector(input bit junk, input bit blk_wr);
    logic [SW-1:0] e;
    bit ok, all_ok, rdy_ok;
    int a;
    e = model_sum();
    all_ok = 1'b1;
    a = 0;
    for (int i = 0; i < NW; i++) begin
      repeat (gap[i]) @(negedge clk);
      send_word(vec[i], ok, a);
      all_ok &= ok;
    end
    if (!all_ok) return;
    exp_q.push_back(e);
    cyc_q.push_back(a);
    rdy_ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (junk) begin
        in_valid = 1'b1;
        in_data = DW'($urandom);
      end
      if (blk_wr && k == 1) begin
        w_wen = 1'b1; w_addr = '0; w_data = '0;
        b_wen = 1'b1; b_data = 32'h4000_0000;
      end else begin
        w_wen = 1'b0; b_wen = 1'b0;
      end
      if (in_ready !== 1'b0) rdy_ok = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0; w_wen = 1'b0; b_wen = 1'b0;
    check("in_ready_low_in_drain", rdy_ok, 1);
    check("in_ready_back_high", in_ready, 1);
    last_sum = e;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [SW-1:0] e;
    int a;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_out_valid: got sum %0h expected no strobe", out_sum);
      end else begin
        e = exp_q.pop_front();
        a = cyc_q.pop_front();
        check("out_sum", out_sum, e);
        check("out_valid_latency", cyc, a + 5);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int a;
    for (int i = 0; i < NW; i++) begin wm[i] = '0; vec[i] = '0; gap[i] = 0; end
    bm = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_sum", out_sum, 0);
    check("reset_in_ready", in_ready, 1);

    // basic sum
    for (int i = 0; i < NW; i++) write_weight(i, 16'h1000);
    write_bias('0);
    for (int i = 0; i < NW; i++) begin vec[i] = 16'h1000; gap[i] = 0; end
    send_vector(1'b0, 1'b0);

    // positive saturation
    for (int i = 0; i < NW; i++) write_weight(i, 16'h7FFF);
    for (int i = 0; i < NW; i++) vec[i] = 16'h7FFF;
    send_vector(1'b0, 1'b0);

    // negative saturation
    for (int i = 0; i < NW; i++) vec[i] = 16'h8000;
    send_vector(1'b0, 1'b0);

    // bias and gaps, then the same vector again
    for (int i = 0; i < NW; i++) write_weight(i, DW'(i + 1));
    write_bias(32'h0000_0010);
    for (int i = 0; i < NW; i++) begin vec[i] = 16'h0001; gap[i] = i + 1; end
    send_vector(1'b0, 1'b0);
    send_vector(1'b0, 1'b0);

    // reset mid-vector: two words dropped, weights kept
    send_word(16'h7FFF, ok, a);
    send_word(16'h7FFF, ok, a);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midreset_out_sum", out_sum, 0);
    check("midreset_in_ready", in_ready, 1);
    for (int i = 0; i < NW; i++) begin vec[i] = 16'h0002; gap[i] = 0; end
    send_vector(1'b0, 1'b0);

    // writes during drain are dropped; junk words during drain are ignored
    for (int i = 0; i < NW; i++) vec[i] = 16'h0001;
    send_vector(1'b1, 1'b1);
    send_vector(1'b0, 1'b0);

    // out-of-range weight address is ignored
    write_weight(NW, 16'h7FFF);
    write_weight(NW + 3, 16'h1234);
    send_vector(1'b0, 1'b0);

    // randomised vectors
    for (int r = 0; r < 14; r++) begin
      if ($urandom_range(0, 2) == 0)
        for (int i = 0; i < NW; i++) write_weight(i, rand_word());
      if ($urandom_range(0, 1) == 1) write_bias(SW'($urandom));
      if ($urandom_range(0, 3) == 0) write_weight($urandom_range(NW, 7), rand_word());
      for (int i = 0; i < NW; i++) begin
        vec[i] = rand_word();
        gap[i] = $urandom_range(0, 2);
      end
      send_vector(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // wrap up
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    check("out_sum_held", out_sum, last_sum);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
